dispatch_credit_ctrl: RTL and testbench

Credit-based dispatch controller between the instruction queue and the decoder/back-end. Tracks free entries in the ROB, RS and LSQ, and drives the three ready inputs that gate instruction-queue issue. Also sequences flush recovery.
Sits beside the instruction queue. Consumes decoder dispatch events and back-end release events.

---
 rtl/dispatch_credit_ctrl.sv | 155 +++++++++++++++
 tb/tb_dispatch_credit_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_credit_ctrl.sv
// rtl/dispatch_credit_ctrl.sv - ROB/RS/LSQ credit tracking and flush sequencing for dispatch
// Optional DISPATCH_STAT_EN adds per-queue RUN-state stall counters.
module dispatch_credit_ctrl #(
  parameter int ROB_DEPTH  = 16,
  parameter int RS_DEPTH   = 16,
  parameter int LSQ_DEPTH  = 8,
  parameter int CNT_W      = 5,
  parameter int SLACK      = 2,
  parameter int FLUSH_HOLD = 3
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             rob_flush_in,
  input  logic             decoder_en_in,
  input  logic             decoder_is_mem_in,
  input  logic             rob_commit_in,
  input  logic             rs_issue_in,
  input  logic             lsq_issue_in,
  output logic             rob_rdy_out,
  output logic             rs_rdy_out,
  output logic             lsqueue_rdy_out,
  output logic [CNT_W-1:0] rob_free_out,
  output logic             err_out
`ifdef DISPATCH_STAT_EN
  ,
  output logic [31:0]      stall_rob_out,
  output logic [31:0]      stall_rs_out,
  output logic [31:0]      stall_lsq_out
`endif
);

  localparam int HOLD_W = $clog2(FLUSH_HOLD + 1);
  localparam logic [CNT_W-1:0]  ROB_FULL  = CNT_W'(ROB_DEPTH);
  localparam logic [CNT_W-1:0]  RS_FULL   = CNT_W'(RS_DEPTH);
  localparam logic [CNT_W-1:0]  LSQ_FULL  = CNT_W'(LSQ_DEPTH);
  localparam logic [CNT_W-1:0]  SLACK_C   = CNT_W'(SLACK);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FLUSH_HOLD);

  typedef enum logic {ST_RUN, ST_FLUSH} state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  rob_q, rob_d;
  logic [CNT_W-1:0]  rs_q, rs_d;
  logic [CNT_W-1:0]  lsq_q, lsq_d;
  logic              err_q, err_d;
  logic              rob_rdy_q, rob_rdy_d;
  logic              rs_rdy_q, rs_rdy_d;
  logic              lsq_rdy_q, lsq_rdy_d;

  logic rob_alloc, rs_alloc, lsq_alloc;

  // Saturating credit step: an alloc at empty or a release at full leaves the count alone.
  function automatic logic [CNT_W-1:0] credit_step(input logic [CNT_W-1:0] free,
                                                   input logic alloc, input logic rel,
                                                   input logic [CNT_W-1:0] full);
    credit_step = free;
    if (alloc && !rel && free != '0) credit_step = free - CNT_W'(1);
    else if (rel && !alloc && free != full) credit_step = free + CNT_W'(1);
  endfunction

  function automatic logic credit_bad(input logic [CNT_W-1:0] free,
                                      input logic alloc, input logic rel,
                                      input logic [CNT_W-1:0] full);
    credit_bad = (alloc && !rel && free == '0) || (rel && !alloc && free == full);
  endfunction

  assign rob_alloc = decoder_en_in;
  assign rs_alloc  = decoder_en_in && !decoder_is_mem_in;
  assign lsq_alloc = decoder_en_in && decoder_is_mem_in;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rob_d   = rob_q;
    rs_d    = rs_q;
    lsq_d   = lsq_q;
    err_d   = err_q;
    if (rob_flush_in) begin
      state_d = ST_FLUSH;
      hold_d  = HOLD_INIT;
      rob_d   = ROB_FULL;
      rs_d    = RS_FULL;
      lsq_d   = LSQ_FULL;
    end else if (state_q == ST_FLUSH) begin
      // Credits stay full while draining; a dispatch here means the issue gate was ignored.
      if (decoder_en_in) err_d = 1'b1;
      if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
      if (hold_q <= HOLD_W'(1)) state_d = ST_RUN;
    end else begin
      rob_d = credit_step(rob_q, rob_alloc, rob_commit_in, ROB_FULL);
      rs_d  = credit_step(rs_q, rs_alloc, rs_issue_in, RS_FULL);
      lsq_d = credit_step(lsq_q, lsq_alloc, lsq_issue_in, LSQ_FULL);
      if (credit_bad(rob_q, rob_alloc, rob_commit_in, ROB_FULL) ||
          credit_bad(rs_q, rs_alloc, rs_issue_in, RS_FULL) ||
          credit_bad(lsq_q, lsq_alloc, lsq_issue_in, LSQ_FULL))
        err_d = 1'b1;
    end
    rob_rdy_d = (state_d == ST_RUN) && (rob_d > SLACK_C);
    rs_rdy_d  = (state_d == ST_RUN) && (rs_d > SLACK_C);
    lsq_rdy_d = (state_d == ST_RUN) && (lsq_d > SLACK_C);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= ST_FLUSH;
      hold_q    <= HOLD_INIT;
      rob_q     <= ROB_FULL;
      rs_q      <= RS_FULL;
      lsq_q     <= LSQ_FULL;
      err_q     <= 1'b0;
      rob_rdy_q <= 1'b0;
      rs_rdy_q  <= 1'b0;
      lsq_rdy_q <= 1'b0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rob_q     <= rob_d;
      rs_q      <= rs_d;
      lsq_q     <= lsq_d;
      err_q     <= err_d;
      rob_rdy_q <= rob_rdy_d;
      rs_rdy_q  <= rs_rdy_d;
      lsq_rdy_q <= lsq_rdy_d;
    end
  end

`ifdef DISPATCH_STAT_EN
  logic [31:0] stall_rob_q, stall_rs_q, stall_lsq_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stall_rob_q <= '0;
      stall_rs_q  <= '0;
      stall_lsq_q <= '0;
    end else if (rdy_in && state_q == ST_RUN) begin
      if (!rob_rdy_q) stall_rob_q <= stall_rob_q + 32'd1;
      if (!rs_rdy_q)  stall_rs_q  <= stall_rs_q + 32'd1;
      if (!lsq_rdy_q) stall_lsq_q <= stall_lsq_q + 32'd1;
    end
  end

  assign stall_rob_out = stall_rob_q;
  assign stall_rs_out  = stall_rs_q;
  assign stall_lsq_out = stall_lsq_q;
`endif

  assign rob_rdy_out     = rob_rdy_q;
  assign rs_rdy_out      = rs_rdy_q;
  assign lsqueue_rdy_out = lsq_rdy_q;
  assign rob_free_out    = rob_q;
  assign err_out         = err_q;

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// tb/tb_dispatch_credit_ctrl.sv - directed self-checking bench for dispatch_credit_ctrl
module tb_dispatch_credit_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n_in, rdy_in, rob_flush_in, decoder_en_in, decoder_is_mem_in;
  logic       rob_commit_in, rs_issue_in, lsq_issue_in;
  logic       rob_rdy_out, rs_rdy_out, lsqueue_rdy_out, err_out;
  logic [4:0] rob_free_out;
  logic [2:0] rdy_v;
`ifdef DISPATCH_STAT_EN
  logic [31:0] stall_rob_out, stall_rs_out, stall_lsq_out;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  assign rdy_v = {rob_rdy_out, rs_rdy_out, lsqueue_rdy_out};

  dispatch_credit_ctrl dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_flush_in(rob_flush_in),
    .decoder_en_in(decoder_en_in), .decoder_is_mem_in(decoder_is_mem_in),
    .rob_commit_in(rob_commit_in), .rs_issue_in(rs_issue_in), .lsq_issue_in(lsq_issue_in),
    .rob_rdy_out(rob_rdy_out), .rs_rdy_out(rs_rdy_out), .lsqueue_rdy_out(lsqueue_rdy_out),
    .rob_free_out(rob_free_out), .err_out(err_out)
`ifdef DISPATCH_STAT_EN
    , .stall_rob_out(stall_rob_out), .stall_rs_out(stall_rs_out), .stall_lsq_out(stall_lsq_out)
`endif
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_in();
    rob_flush_in = 1'b0; decoder_en_in = 1'b0; decoder_is_mem_in = 1'b0;
    rob_commit_in = 1'b0; rs_issue_in = 1'b0; lsq_issue_in = 1'b0;
  endtask

  task automatic reset_to_run();
    clear_in();
    rdy_in = 1'b1;
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; rdy_in = 1'b1; clear_in();
    #12;
    n_cmp++; if (rdy_v !== 3'b000) begin n_fail++; $display("FAIL reset_rdy got %b want 000", rdy_v); end
    n_cmp++; if (rob_free_out !== 5'd16) begin n_fail++; $display("FAIL reset_free got %0d want 16", rob_free_out); end
    n_cmp++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_out); end
    tick();
    rst_n_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (rdy_v !== ((i == 3) ? 3'b111 : 3'b000)) begin
        n_fail++; $display("FAIL reset_window cycle %0d got %b want %b", i, rdy_v, (i == 3) ? 3'b111 : 3'b000);
      end
    end
    n_cmp++; if (rob_free_out !== 5'd16) begin n_fail++; $display("FAIL reset_run_free got %0d want 16", rob_free_out); end
  endtask

  task automatic test_nonmem();
    logic e;
    for (int k = 1; k <= 14; k++) begin
      decoder_en_in = 1'b1; decoder_is_mem_in = 1'b0;
      tick();
      e = (16 - k) > 2;
      n_cmp++;
      if (rob_free_out !== 5'(16 - k)) begin n_fail++; $display("FAIL nonmem_free k=%0d got %0d want %0d", k, rob_free_out, 16 - k); end
      n_cmp++;
      if (rdy_v !== {e, e, 1'b1}) begin n_fail++; $display("FAIL nonmem_rdy k=%0d got %b want %b", k, rdy_v, {e, e, 1'b1}); end
    end
    clear_in();
    n_cmp++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL nonmem_err got %b want 0", err_out); end
    rob_commit_in = 1'b1; rs_issue_in = 1'b1;
    repeat (14) tick();
    clear_in();
    n_cmp++; if (rob_free_out !== 5'd16) begin n_fail++; $display("FAIL nonmem_restore got %0d want 16", rob_free_out); end
    n_cmp++; if (rdy_v !== 3'b111) begin n_fail++; $display("FAIL nonmem_restore_rdy got %b want 111", rdy_v); end
  endtask

  task automatic test_mem();
    for (int k = 1; k <= 6; k++) begin
      decoder_en_in = 1'b1; decoder_is_mem_in = 1'b1; lsq_issue_in = k[0];
      tick();
    end
    clear_in();
    n_cmp++; if (rob_free_out !== 5'd10) begin n_fail++; $display("FAIL mem_rob_free got %0d want 10", rob_free_out); end
    n_cmp++; if (rdy_v !== 3'b111) begin n_fail++; $display("FAIL mem_rdy got %b want 111", rdy_v); end
    // LSQ at 5: two more dispatches keep it above slack, the third drops it to 2
    for (int k = 1; k <= 3; k++) begin
      decoder_en_in = 1'b1; decoder_is_mem_in = 1'b1;
      tick();
      n_cmp++;
      if (lsqueue_rdy_out !== (k < 3)) begin n_fail++; $display("FAIL mem_lsq_rdy k=%0d got %b want %b", k, lsqueue_rdy_out, k < 3); end
    end
    clear_in();
    n_cmp++; if (rob_free_out !== 5'd7) begin n_fail++; $display("FAIL mem_rob_free2 got %0d want 7", rob_free_out); end
    for (int k = 0; k < 9; k++) begin
      rob_commit_in = 1'b1; lsq_issue_in = (k < 6);
      tick();
    end
    clear_in();
    n_cmp++; if (rdy_v !== 3'b111 || rob_free_out !== 5'd16 || err_out !== 1'b0) begin
      n_fail++; $display("FAIL mem_restore got rdy=%b free=%0d err=%b want 111/16/0", rdy_v, rob_free_out, err_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++) begin
      decoder_en_in = 1'b1; rob_commit_in = 1'b1; rs_issue_in = 1'b1;
      tick();
      n_cmp++;
      if (rob_free_out !== 5'd16) begin n_fail++; $display("FAIL b2b_free k=%0d got %0d want 16", k, rob_free_out); end
    end
    clear_in();
    n_cmp++; if (err_out !== 1'b0 || rdy_v !== 3'b111) begin
      n_fail++; $display("FAIL b2b_end got err=%b rdy=%b want 0/111", err_out, rdy_v);
    end
  endtask

  task automatic test_flush();
    decoder_en_in = 1'b1;
    repeat (3) tick();
    clear_in();
    n_cmp++; if (rob_free_out !== 5'd13) begin n_fail++; $display("FAIL flush_pre got %0d want 13", rob_free_out); end
    rob_flush_in = 1'b1; decoder_en_in = 1'b1; rob_commit_in = 1'b1;
    tick();
    clear_in();
    n_cmp++; if (rob_free_out !== 5'd16 || rdy_v !== 3'b000 || err_out !== 1'b0) begin
      n_fail++; $display("FAIL flush_entry got free=%0d rdy=%b err=%b want 16/000/0", rob_free_out, rdy_v, err_out);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (rdy_v !== ((i == 3) ? 3'b111 : 3'b000)) begin n_fail++; $display("FAIL flush_window cycle %0d got %b", i, rdy_v); end
    end
    rob_flush_in = 1'b1; tick(); clear_in();
    repeat (2) tick();
    rob_flush_in = 1'b1; tick(); clear_in();
    n_cmp++; if (rdy_v !== 3'b000) begin n_fail++; $display("FAIL reflush_entry got %b want 000", rdy_v); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (rdy_v !== ((i == 3) ? 3'b111 : 3'b000)) begin n_fail++; $display("FAIL reflush_window cycle %0d got %b", i, rdy_v); end
    end
    n_cmp++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL flush_err got %b want 0", err_out); end
  endtask

  task automatic test_enable();
    rdy_in = 1'b0; decoder_en_in = 1'b1; rob_flush_in = 1'b1;
    repeat (3) tick();
    clear_in();
    n_cmp++; if (rob_free_out !== 5'd16 || rdy_v !== 3'b111) begin
      n_fail++; $display("FAIL enable_hold got free=%0d rdy=%b want 16/111", rob_free_out, rdy_v);
    end
    rdy_in = 1'b1; rob_flush_in = 1'b1; tick(); clear_in();
    rdy_in = 1'b0;
    repeat (4) tick();
    rdy_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (rdy_v !== ((i == 3) ? 3'b111 : 3'b000)) begin n_fail++; $display("FAIL enable_flush cycle %0d got %b", i, rdy_v); end
    end
  endtask

  task automatic test_overflow_err();
    rob_commit_in = 1'b1; tick(); clear_in();
    n_cmp++; if (err_out !== 1'b1 || rob_free_out !== 5'd16) begin
      n_fail++; $display("FAIL ovf got err=%b free=%0d want 1/16", err_out, rob_free_out);
    end
    repeat (2) tick();
    n_cmp++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", err_out); end
    #3 rst_n_in = 1'b0;
    #1;
    n_cmp++; if (err_out !== 1'b0 || rdy_v !== 3'b000 || rob_free_out !== 5'd16) begin
      n_fail++; $display("FAIL async_rst got err=%b rdy=%b free=%0d want 0/000/16", err_out, rdy_v, rob_free_out);
    end
    rst_n_in = 1'b1;
    repeat (3) tick();
    n_cmp++; if (rdy_v !== 3'b111) begin n_fail++; $display("FAIL async_rst_run got %b want 111", rdy_v); end
  endtask

  task automatic test_underflow_err();
    for (int k = 1; k <= 9; k++) begin
      decoder_en_in = 1'b1; decoder_is_mem_in = 1'b1;
      tick();
      if (k == 8) begin
        n_cmp++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL udf_early got %b want 0", err_out); end
      end
    end
    clear_in();
    n_cmp++; if (err_out !== 1'b1 || rob_free_out !== 5'd7 || lsqueue_rdy_out !== 1'b0) begin
      n_fail++; $display("FAIL udf got err=%b free=%0d lsq=%b want 1/7/0", err_out, rob_free_out, lsqueue_rdy_out);
    end
    rob_flush_in = 1'b1; tick(); clear_in();
    n_cmp++; if (err_out !== 1'b1 || rob_free_out !== 5'd16) begin
      n_fail++; $display("FAIL udf_flush got err=%b free=%0d want 1/16", err_out, rob_free_out);
    end
  endtask

  task automatic test_flush_dispatch_err();
    reset_to_run();
    rob_flush_in = 1'b1; tick(); clear_in();
    decoder_en_in = 1'b1; tick(); clear_in();
    n_cmp++; if (err_out !== 1'b1 || rob_free_out !== 5'd16) begin
      n_fail++; $display("FAIL flush_dispatch got err=%b free=%0d want 1/16", err_out, rob_free_out);
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_mem();
    test_back_to_back();
    test_flush();
    test_enable();
    test_overflow_err();
    test_underflow_err();
    test_flush_dispatch_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
